nios_pio_status_in: RTL and testbench
=====================================

Name: nios_pio_status_in

Overview:
- Avalon-MM slave input PIO that returns a status word from the DSP fabric to the Nios CPU. Typical sources are ADC overflow, DDC/NCO lock and FIFO flags.
- It is the read-direction counterpart of the frequency/phase output PIOs and shares their s1 register map convention.
- It synchronises the input bus, detects edges per bit, latches them in a write-1-to-clear capture register and raises a maskable level interrupt.

Parameters:
- WIDTH, 22, width of in_port and of every register (1..32).
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on in_port (0 = bypass, 2..3 typical).
- EDGE_TYPE, 0, edge detected per bit: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0, reset value of the synchroniser and edge-history registers.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  s1 word address
- chipselect  in  1  s1 select
- write_n  in  1  s1 write strobe, active low
- writedata  in  32  s1 write data
- readdata  out  32  s1 read data, registered
- in_port  in  WIDTH  status inputs, asynchronous to clk
- irq  out  1  level interrupt, active high

Behaviour:
- Reset (asynchronous, active-low):
  - readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0.
  - Synchroniser and edge-history registers = RESET_VALUE.
- Synchroniser: in_port passes through SYNC_STAGES flops to give in_sync. in_hist is in_sync delayed by 1 clk.
- Edge detect, combinational per bit:
  - rise = in_sync & ~in_hist
  - fall = ~in_sync & in_hist
  - edge = rise, fall or rise|fall, selected by EDGE_TYPE.
- Register map (wr = chipselect & ~write_n):
  - addr 0 DATA: read-only, returns in_sync. Writes are ignored.
  - addr 1 DIRECTION: not implemented. Reads 0, writes ignored.
  - addr 2 IRQ_MASK: read/write, bits [WIDTH-1:0]. Written on wr; upper writedata bits are discarded.
  - addr 3 EDGE_CAPTURE: write-1-to-clear. For each bit, next value = (cur & ~(wr3 ? writedata : 0)) | edge.
- Set/clear collision: if an edge and a clear hit the same bit in the same cycle, set dominates and the bit stays 1. No event is lost.
- Read latency 1 cycle:
  - readdata is registered every clk with the mux of address, zero-extended to 32 bits.
  - chipselect does not gate the register update.
  - The Avalon read latency for s1 is declared as 1.
- Interrupt:
  - irq is registered: irq <= |(edge_capture & irq_mask).
  - Latency is 1 clk after the edge_capture bit sets.
  - Deasserts 1 clk after the last offending bit is cleared or masked.
- Input latency: an in_port change shows in DATA reads after SYNC_STAGES+1 clk (sync stages plus the readdata register). It sets edge_capture SYNC_STAGES+1 clk after the change, and irq follows one clk later.
- Glitches shorter than 1 clk may be missed. This is not detected or flagged.
- Writes to address 0 or 1 have no side effects.
- Reset mid-operation: all state returns to reset values immediately. Edges pending at the moment of reset are discarded.
- No handshake stalls: the slave has zero wait states and accepts back-to-back reads and writes every cycle.

Decomposition:
- Shared package nios_pio_pkg holds:
  - address constants PIO_ADDR_DATA = 0, PIO_ADDR_DIR = 1, PIO_ADDR_IRQMASK = 2, PIO_ADDR_EDGECAP = 3;
  - edge-type constants EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- One sub-module, pio_bit_sync: a parameterised WIDTH x SYNC_STAGES synchroniser with asynchronous reset to RESET_VALUE.
- Edge detection, capture, mask and the read mux live in the top level.

Test Plan:
- Reset check: hold reset_n = 0 with in_port = 0x3FFFFF, then release. Read addr 0/2/3 -> 0x3FFFFF (after sync), 0x0, 0x3FFFFF; readdata = 0 and irq = 0 during reset. With RESET_VALUE = 0 the rising edges on release are captured, so edge_capture = 0x3FFFFF.
- Rising-edge capture and irq: write IRQ_MASK = 0x000001, clear EDGE_CAPTURE with 0x3FFFFF, then drive in_port bit0 0 -> 1. EDGE_CAPTURE reads 0x000001; irq rises exactly SYNC_STAGES+2 clk after the in_port change.
- W1C and collision: write 0x000001 to addr 3 in the same cycle a new bit0 edge is detected -> bit0 stays 1 and irq stays high. A later clear with no edge -> bit0 = 0 and irq drops 1 clk after.
- Masking: edges on bits 5 and 21 with mask = 0x000020 -> irq = 1. Write mask = 0 -> irq = 0 the next clk, and EDGE_CAPTURE still reads 0x200020.
- Falling/any edge: EDGE_TYPE = 1 and bit3 1 -> 0 captures bit3; a 0 -> 1 transition does not. EDGE_TYPE = 2 captures both directions.
- Register map and latency: back-to-back reads of addr 0, 1, 2, 3 return the matching values each one cycle later, with addr 1 = 0. A write of 0xFFFFFFFF to addr 0 does not change DATA, and the upper 10 bits of IRQ_MASK read 0.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO blocks.
// Holds the s1 word addresses, the edge-type selectors and the s1 read latency.
package nios_pio_pkg;

    // s1 word addresses
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Per-bit edge selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // readdata is valid one clk after the address is presented
    localparam int PIO_READ_LATENCY = 1;

endpackage

// File: rtl/pio_bit_sync.sv
// Multi-bit flip-flop synchroniser with asynchronous reset to RESET_VALUE.
// Each bit is synchronised independently, so the output is not a coherent
// bus sample. SYNC_STAGES = 0 turns the block into a wire.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   d        asynchronous input bus
//   q        synchronised output bus
module pio_bit_sync #(
    parameter int               WIDTH       = 22,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [WIDTH-1:0] stage [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= RESET_VALUE;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/nios_pio_status_in.sv
// Avalon-MM input PIO returning a status word from the DSP fabric to Nios.
// in_port is synchronised, edges are detected per bit and latched in a
// write-1-to-clear capture register, and a maskable level irq is raised.
// s1 map: 0 DATA (RO), 1 DIRECTION (reads 0), 2 IRQ_MASK (RW),
//         3 EDGE_CAPTURE (W1C). Zero wait states, read latency 1.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     s1 word address
//   chipselect  s1 select
//   write_n     s1 write strobe, active low
//   writedata   s1 write data
//   readdata    s1 read data, registered
//   in_port     status inputs, asynchronous to clk
//   irq         level interrupt, active high
module nios_pio_status_in
    import nios_pio_pkg::*;
#(
    parameter int               WIDTH       = 22,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_hist;
    logic [WIDTH-1:0] edge_rise;
    logic [WIDTH-1:0] edge_fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_writedata;

    // Upper writedata bits beyond WIDTH have no destination.
    assign unused_writedata = &{1'b0, writedata};

    pio_bit_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (in_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_hist <= RESET_VALUE;
        end else begin
            in_hist <= in_sync;
        end
    end

    assign edge_rise = in_sync & ~in_hist;
    assign edge_fall = ~in_sync & in_hist;

    always_comb begin
        edge_det = edge_rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = edge_fall;
            EDGE_ANY:  edge_det = edge_rise | edge_fall;
            default:   edge_det = edge_rise;
        endcase
    end

    assign wr      = chipselect & ~write_n;
    assign cap_clr = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Clear is applied before set, so an edge arriving together with a
    // clear of the same bit keeps the bit at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~cap_clr) | edge_det;
            if (wr && address == PIO_ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = in_sync;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
            default:          rd_mux = '0;
        endcase
    end

    // readdata is refreshed every clk regardless of chipselect; the master
    // only looks at it one cycle after issuing a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_nios_pio_status_in.sv
module tb_nios_pio_status_in;

    localparam int W = 22;

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata0, readdata1, readdata2;
    logic          irq0, irq1, irq2;

    int            errors = 0;
    int            checks = 0;
    logic          rd_issue = 1'b0;

    string         q_tag[$];
    logic [2:0]    q_en[$];
    logic [31:0]   q_e0[$], q_e1[$], q_e2[$];

    nios_pio_status_in #(.EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0),
        .in_port(in_port), .irq(irq0));

    nios_pio_status_in #(.EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1),
        .in_port(in_port), .irq(irq1));

    nios_pio_status_in #(.EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata2),
        .in_port(in_port), .irq(irq2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: a read driven on a negedge is answered at the next posedge.
    string       m_tag;
    logic [2:0]  m_en;
    logic [31:0] m_e0, m_e1, m_e2;
    always @(posedge clk) begin
        if (rd_issue) begin
            #1;
            if (q_tag.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                m_tag = q_tag.pop_front();
                m_en  = q_en.pop_front();
                m_e0  = q_e0.pop_front();
                m_e1  = q_e1.pop_front();
                m_e2  = q_e2.pop_front();
                if (m_en[0]) chk({m_tag, "_rise"}, readdata0, m_e0);
                if (m_en[1]) chk({m_tag, "_fall"}, readdata1, m_e1);
                if (m_en[2]) chk({m_tag, "_any"},  readdata2, m_e2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        rd_issue   = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [2:0] en,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        rd_issue   = 1'b1;
        q_tag.push_back(tag);
        q_en.push_back(en);
        q_e0.push_back(e0);
        q_e1.push_back(e1);
        q_e2.push_back(e2);
    endtask

    task automatic rd_end();
        @(negedge clk);
        chipselect = 1'b0;
        rd_issue   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 22'h3FFFFF;
        #2 reset_n = 1'b0;
        wait_neg(3);
        chk("rst_readdata", readdata0, 32'h0);
        chk("rst_irq", {31'd0, irq0}, 32'h0);
        chk("rst_irq_any", {31'd0, irq2}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_neg(6);

        // Reset release: in_sync climbs from 0, so rising edges are captured
        rd(2'd0, "rst_data", 3'b111, 32'h3FFFFF, 32'h3FFFFF, 32'h3FFFFF);
        rd(2'd2, "rst_mask", 3'b111, 32'h0, 32'h0, 32'h0);
        rd(2'd3, "rst_cap",  3'b111, 32'h3FFFFF, 32'h0, 32'h3FFFFF);
        rd_end();
        chk("rst_irq_after", {31'd0, irq0}, 32'h0);

        // Rising edge capture and irq latency
        @(negedge clk);
        in_port = 22'h3FFFFE;
        wait_neg(5);
        wr(2'd2, 32'h1);
        wr(2'd3, 32'h3FFFFF);
        wait_neg(2);
        chk("rise_irq_idle", {31'd0, irq0}, 32'h0);
        @(negedge clk);
        in_port = 22'h3FFFFF;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rise_irq_lat%0d", k), {31'd0, irq0}, (k == 4) ? 32'h1 : 32'h0);
        end
        chk("rise_irq_fallunit", {31'd0, irq1}, 32'h0);
        chk("rise_irq_anyunit", {31'd0, irq2}, 32'h1);
        rd(2'd3, "rise_cap", 3'b001, 32'h1, 32'h0, 32'h0);
        rd_end();

        // Clear and new edge in the same cycle: set wins
        @(negedge clk);
        in_port = 22'h3FFFFE;
        wait_neg(5);
        @(negedge clk);
        in_port = 22'h3FFFFF;
        wait_neg(1);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h1;
        @(posedge clk);
        #1;
        chk("coll_irq_a", {31'd0, irq0}, 32'h1);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("coll_irq_b", {31'd0, irq0}, 32'h1);
        rd(2'd3, "coll_cap", 3'b001, 32'h1, 32'h0, 32'h0);
        rd_end();

        // Clear with no edge: irq drops one clk after the bit clears
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'h1;
        @(posedge clk);
        #1;
        chk("clr_irq_hold", {31'd0, irq0}, 32'h1);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_irq_drop", {31'd0, irq0}, 32'h0);
        rd(2'd3, "clr_cap", 3'b001, 32'h0, 32'h0, 32'h0);
        rd_end();

        // Masking
        wr(2'd2, 32'h20);
        wr(2'd3, 32'h3FFFFF);
        @(negedge clk);
        in_port = 22'h1FFFDF;
        wait_neg(5);
        wr(2'd3, 32'h3FFFFF);
        @(negedge clk);
        in_port = 22'h3FFFFF;
        wait_neg(6);
        chk("mask_irq_on", {31'd0, irq0}, 32'h1);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'h0;
        @(posedge clk);
        #1;
        chk("mask_irq_hold", {31'd0, irq0}, 32'h1);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("mask_irq_off", {31'd0, irq0}, 32'h0);
        rd(2'd3, "mask_cap", 3'b001, 32'h200020, 32'h0, 32'h0);
        rd(2'd2, "mask_reg", 3'b111, 32'h0, 32'h0, 32'h0);
        rd_end();

        // Falling and any-edge units
        wr(2'd3, 32'h3FFFFF);
        @(negedge clk);
        in_port = 22'h3FFFF7;
        wait_neg(6);
        rd(2'd3, "fall_cap", 3'b111, 32'h0, 32'h8, 32'h8);
        rd_end();
        wr(2'd3, 32'h3FFFFF);
        @(negedge clk);
        in_port = 22'h3FFFFF;
        wait_neg(6);
        rd(2'd3, "rise2_cap", 3'b111, 32'h8, 32'h0, 32'h8);
        rd_end();

        // Register map, back-to-back reads
        wr(2'd2, 32'h155);
        rd(2'd0, "map_data", 3'b111, 32'h3FFFFF, 32'h3FFFFF, 32'h3FFFFF);
        rd(2'd1, "map_dir",  3'b111, 32'h0, 32'h0, 32'h0);
        rd(2'd2, "map_mask", 3'b111, 32'h155, 32'h155, 32'h155);
        rd(2'd3, "map_cap",  3'b111, 32'h8, 32'h0, 32'h8);
        rd_end();
        wr(2'd0, 32'hFFFFFFFF);
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd0, "ro_data", 3'b001, 32'h3FFFFF, 32'h0, 32'h0);
        rd(2'd1, "ro_dir",  3'b001, 32'h0, 32'h0, 32'h0);
        rd(2'd3, "ro_cap",  3'b001, 32'h8, 32'h0, 32'h0);
        rd_end();
        wr(2'd2, 32'hFFFFFFFF);
        rd(2'd2, "mask_upper", 3'b001, 32'h3FFFFF, 32'h0, 32'h0);
        rd_end();

        // DATA latency with chipselect low: readdata still tracks address 0
        @(negedge clk);
        address    = 2'd0;
        chipselect = 1'b0;
        wait_neg(2);
        in_port = 22'h15A5A5;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("data_lat%0d", k), readdata0, (k == 3) ? 32'h15A5A5 : 32'h3FFFFF);
        end

        // Reset mid-operation
        @(negedge clk);
        in_port = 22'h3FFFFF;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_readdata", readdata0, 32'h0);
        chk("midrst_irq", {31'd0, irq0}, 32'h0);
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(2);

        chk("sb_empty", q_tag.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
